// File: rtl/he_frame_ctrl.sv
// Histogram-equalisation frame controller: clears a 256-bin histogram, counts one
// frame of pixels into it, then walks the bins to emit a cumulative-distribution LUT.
module he_frame_ctrl #(
  parameter int unsigned NUM_PIXELS = 290400,
  parameter int unsigned NUM_BINS   = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in_pixel,
  output logic        in_ready,
  output logic        hist_clr_en,
  output logic        hist_inc_en,
  output logic        hist_rd_en,
  output logic [7:0]  hist_addr,
  input  logic [19:0] hist_rd_data,
  output logic        lut_wr_en,
  output logic [7:0]  lut_wr_addr,
  output logic [7:0]  lut_wr_data,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_HIST,
    S_CDF,
    S_FINISH
  } state_e;

  localparam logic [8:0]  LAST_BIN = 9'(NUM_BINS - 1);
  localparam logic [8:0]  BIN_END  = 9'(NUM_BINS);
  localparam logic [19:0] LAST_PIX = 20'(NUM_PIXELS - 1);
  localparam logic [27:0] NPIX     = 28'(NUM_PIXELS);

  state_e      state_q, state_d;
  logic [8:0]  bin_cnt_q, bin_cnt_d;
  logic [19:0] pix_cnt_q, pix_cnt_d;
  logic [19:0] cdf_q, cdf_d;
  logic        rd_vld_q;
  logic [7:0]  rd_addr_q;

  logic [19:0] cdf_sum;
  logic [27:0] scaled;
  logic [27:0] quot;

  // Read data returns one cycle after the address, so the accumulate and the LUT
  // write for bin k both happen in the cycle after bin k is read.
  assign cdf_sum     = cdf_q + hist_rd_data;
  assign scaled      = 28'(cdf_sum) * 28'd255;
  assign quot        = scaled / NPIX;
  assign lut_wr_en   = rd_vld_q;
  assign lut_wr_addr = rd_vld_q ? rd_addr_q : 8'd0;
  assign lut_wr_data = !rd_vld_q      ? 8'd0 :
                       (quot > 28'd255) ? 8'd255 : quot[7:0];

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      state_q   <= S_IDLE;
      bin_cnt_q <= '0;
      pix_cnt_q <= '0;
      cdf_q     <= '0;
      rd_vld_q  <= 1'b0;
      rd_addr_q <= '0;
    end else begin
      state_q   <= state_d;
      bin_cnt_q <= bin_cnt_d;
      pix_cnt_q <= pix_cnt_d;
      cdf_q     <= cdf_d;
      rd_vld_q  <= hist_rd_en;
      rd_addr_q <= hist_addr;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first; a path that skips an
    // assignment would otherwise infer a latch.
    state_d     = state_q;
    bin_cnt_d   = bin_cnt_q;
    pix_cnt_d   = pix_cnt_q;
    cdf_d       = cdf_q;
    in_ready    = 1'b0;
    hist_clr_en = 1'b0;
    hist_inc_en = 1'b0;
    hist_rd_en  = 1'b0;
    hist_addr   = 8'd0;
    busy        = 1'b1;
    done        = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_d   = S_CLEAR;
          bin_cnt_d = '0;
          pix_cnt_d = '0;
          cdf_d     = '0;
        end
      end
      S_CLEAR: begin
        hist_clr_en = 1'b1;
        hist_addr   = bin_cnt_q[7:0];
        bin_cnt_d   = bin_cnt_q + 9'd1;
        if (bin_cnt_q == LAST_BIN) begin
          state_d   = S_HIST;
          bin_cnt_d = '0;
        end
      end
      S_HIST: begin
        in_ready = 1'b1;
        if (in_valid) begin
          hist_inc_en = 1'b1;
          hist_addr   = in_pixel;
          pix_cnt_d   = pix_cnt_q + 20'd1;
          if (pix_cnt_q == LAST_PIX) state_d = S_CDF;
        end
      end
      S_CDF: begin
        // One extra cycle after the last read lets the final LUT write drain.
        if (bin_cnt_q != BIN_END) begin
          hist_rd_en = 1'b1;
          hist_addr  = bin_cnt_q[7:0];
          bin_cnt_d  = bin_cnt_q + 9'd1;
        end else begin
          state_d = S_FINISH;
        end
      end
      S_FINISH: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (rd_vld_q) cdf_d = cdf_sum;
  end

endmodule

// File: doc/he_frame_ctrl.md
HE_FRAME_CTRL -- requirements
Module: he_frame_ctrl

Interface
REQ-001 Parameter NUM_PIXELS, default 290400, pixels per frame (660x440); legal range 1..2^20-1.
REQ-002 Parameter NUM_BINS, fixed 256, number of histogram bins and LUT entries.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  one-cycle request to process a frame.
REQ-006 in_valid  input  1  pixel stream valid.
REQ-007 in_pixel  input  8  pixel value.
REQ-008 in_ready  output  1  controller accepts pixel; a beat transfers when in_valid and in_ready are both high.
REQ-009 hist_clr_en  output  1  zero histogram bin hist_addr.
REQ-010 hist_inc_en  output  1  increment histogram bin hist_addr.
REQ-011 hist_rd_en  output  1  read histogram bin hist_addr; data valid on hist_rd_data next cycle.
REQ-012 hist_addr  output  8  bin address for clear/increment/read.
REQ-013 hist_rd_data  input  20  bin count, 1-cycle read latency.
REQ-014 lut_wr_en, lut_wr_addr[7:0], lut_wr_data[7:0]  outputs  write one transformation-table entry.
REQ-015 busy  output  1  high in any state other than IDLE.
REQ-016 done  output  1  one-cycle pulse when LUT is complete.

Function
REQ-017 States SHALL be IDLE, CLEAR, HIST, CDF, FINISH.
- IDLE -> CLEAR on start; start in any other state ignored.
- CLEAR: hist_clr_en=1, hist_addr=0..255 over 256 consecutive cycles; -> HIST after addr 255.
- HIST: in_ready=1; each accepted beat drives hist_inc_en=1, hist_addr=in_pixel in that same cycle; pixel counter +1.
- HIST -> CDF in the cycle the NUM_PIXELS-th beat is accepted; in_ready=0 from the next cycle.
- CDF: hist_rd_en=1, hist_addr=k for k=0..255 on consecutive cycles; one cycle after each read, cdf += hist_rd_data, and the LUT write for bin k is issued.
- FINISH: single cycle, done=1, then -> IDLE.
REQ-018 LUT arithmetic: cdf accumulator 20 bits, reset to 0 on CLEAR entry; lut_wr_data = floor(255*cdf_k/NUM_PIXELS) using a >=28-bit intermediate, where cdf_k includes bin k; result saturates at 255.
REQ-019 LUT writes SHALL occur on exactly 256 consecutive cycles with lut_wr_addr = 0..255 ascending; write for bin 255 is in the cycle before FINISH.
REQ-020 Outside the states named above, hist_clr_en, hist_inc_en, hist_rd_en, lut_wr_en and in_ready SHALL be 0; at most one hist_* enable is high in any cycle.
REQ-021 in_valid while in_ready=0 SHALL be ignored; pixels are not buffered.
REQ-022 Frame latency: start to done = 1 + 256 + (cycles to receive NUM_PIXELS beats) + 256 + 1 cycles, with no additional bubbles.
REQ-023 Pixel counter SHALL be 20 bits and cleared on CLEAR entry; no wrap is possible within legal NUM_PIXELS.
REQ-024 Back-to-back start arriving in the FINISH cycle is ignored; start in the cycle after FINISH (IDLE) is accepted.

Reset
REQ-025 reset high SHALL force state IDLE, counters and cdf to 0, and all outputs to 0 (in_ready, busy, done, all enables, hist_addr, lut_wr_addr, lut_wr_data) on the next edge.
REQ-026 reset asserted mid-frame (any state) SHALL abort with no further histogram or LUT writes; the next start restarts from CLEAR.

Verification
REQ-027 NUM_PIXELS=16, all pixels 0, in_valid constant -> 256 clears, 16 increments to bin 0, LUT entries 0..255 all 255, done at cycle 1+256+16+256+1 after start.
REQ-028 NUM_PIXELS=4, pixels 0,85,170,255, bins modelled -> LUT[0..84]=63, LUT[85..169]=127, LUT[170..254]=191, LUT[255]=255.
REQ-029 in_valid toggled randomly during HIST -> exactly NUM_PIXELS increments, none while in_valid=0, in_ready drops the cycle after the last beat.
REQ-030 start pulsed during CLEAR, HIST, CDF and FINISH -> ignored; no restart, single done pulse.
REQ-031 reset asserted in the middle of the CDF phase -> all enables 0 next cycle, no done; a subsequent frame completes with correct LUT.
REQ-032 Default NUM_PIXELS=290400, uniform pixel ramp -> LUT monotonic non-decreasing, LUT[255]=255, no overflow of the 20-bit cdf.
